// File: rtl/cb_pkg.sv
// Shared sizing helpers and mux track mapping for the parametrised X-channel connection block.
// Pure functions only; evaluated at elaboration time by the blocks that import them.
package cb_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // A 2:1 mux still needs one select bit, so the select width never drops to zero.
    function automatic int sel_w(input int mux_size);
        return (clog2(mux_size) < 1) ? 1 : clog2(mux_size);
    endfunction

    function automatic int cfg_bits(input int num_ipin, input int mux_size);
        return num_ipin * sel_w(mux_size);
    endfunction

    function automatic int track_of(input int i, input int m, input int stride, input int chan_w);
        return (i + m * stride) % chan_w;
    endfunction

    function automatic bit params_ok(input int chan_w, input int mux_size);
        return (chan_w >= 1) && (mux_size >= 2) && ((mux_size % 2) == 0)
            && (mux_size <= 2 * chan_w);
    endfunction

endpackage

// File: rtl/cbx_param_dbuf_if.sv
// Routing-side bundle of the connection block: channel tracks in both directions and grid pins.
// The slave modport is the block itself; the master modport is whatever drives the tracks.
interface cbx_param_dbuf_if #(
    parameter int CHAN_W   = 20,
    parameter int NUM_IPIN = 9
);
    logic [CHAN_W-1:0]   chanx_left_in;
    logic [CHAN_W-1:0]   chanx_right_in;
    logic [CHAN_W-1:0]   chanx_left_out;
    logic [CHAN_W-1:0]   chanx_right_out;
    logic [NUM_IPIN-1:0] ipin_out;

    modport master (
        output chanx_left_in,
        output chanx_right_in,
        input  chanx_left_out,
        input  chanx_right_out,
        input  ipin_out
    );

    modport slave (
        input  chanx_left_in,
        input  chanx_right_in,
        output chanx_left_out,
        output chanx_right_out,
        output ipin_out
    );
endinterface

// File: rtl/cb_cfg_dbuf.sv
// Double-buffered config chain: serial shadow register, bit counter, overrun flag, active register.
// Latency: one prog_clk per chain bit; commit lands on the sampling edge. No backpressure.
module cb_cfg_dbuf
    import cb_pkg::*;
#(
    parameter int CFG_BITS = 36
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                config_enable,
    input  logic                ccff_head,
    input  logic                cfg_commit,
    output logic [CFG_BITS-1:0] act,
    output logic                ccff_tail,
    output logic                cfg_full,
    output logic                cfg_overrun,
    output logic                commit_err
);
    localparam int CNT_W = clog2(CFG_BITS + 1);

    logic [CFG_BITS-1:0] sh_q,  sh_d;
    logic [CFG_BITS-1:0] act_q, act_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovr_q, ovr_d;
    logic                err_q, err_d;
    logic                full;
    logic                accept;

    assign full   = (cnt_q == CNT_W'(CFG_BITS));
    assign accept = cfg_commit && full && !ovr_q;

    always_comb begin
        sh_d  = sh_q;
        act_d = act_q;
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        err_d = 1'b0;

        if (config_enable) begin
            sh_d = (sh_q << 1) | CFG_BITS'(ccff_head);
        end

        if (accept) begin
            // The active copy takes the shadow as it stood before this edge's shift.
            act_d = sh_q;
            cnt_d = config_enable ? CNT_W'(1) : '0;
            ovr_d = 1'b0;
        end else begin
            err_d = cfg_commit;
            if (config_enable) begin
                if (full) ovr_d = 1'b1;
                else      cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sh_q  <= '0;
            act_q <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            act_q <= act_d;
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
            err_q <= err_d;
        end
    end

    assign act         = act_q;
    assign ccff_tail   = sh_q[CFG_BITS-1];
    assign cfg_full    = full;
    assign cfg_overrun = ovr_q;
    assign commit_err  = err_q;

endmodule

// File: rtl/cbx_param_dbuf.sv
// X-channel connection block: NUM_IPIN MUX_SIZE:1 track muxes driven by a double-buffered config.
// Latency: data path and pass-through are combinational; config takes effect after commit. No backpressure.
module cbx_param_dbuf
    import cb_pkg::*;
#(
    parameter int CHAN_W       = 20,
    parameter int NUM_IPIN     = 9,
    parameter int MUX_SIZE     = 10,
    parameter int TRACK_STRIDE = 2
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   config_enable,
    input  logic                   ccff_head,
    input  logic                   cfg_commit,
    output logic                   ccff_tail,
    output logic                   cfg_full,
    output logic                   cfg_overrun,
    output logic                   commit_err,
    cbx_param_dbuf_if.slave        chan
);
    localparam int SEL_W    = sel_w(MUX_SIZE);
    localparam int CFG_BITS = cfg_bits(NUM_IPIN, MUX_SIZE);
    localparam int TW       = (CHAN_W > 1) ? clog2(CHAN_W) : 1;

    if (!params_ok(CHAN_W, MUX_SIZE)) begin : g_bad_params
        $error("cbx_param_dbuf: MUX_SIZE must be even, >= 2 and <= 2*CHAN_W");
    end

    logic [CFG_BITS-1:0] act;
    logic [NUM_IPIN-1:0] ipin;

    cb_cfg_dbuf #(
        .CFG_BITS (CFG_BITS)
    ) u_cfg (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .config_enable (config_enable),
        .ccff_head     (ccff_head),
        .cfg_commit    (cfg_commit),
        .act           (act),
        .ccff_tail     (ccff_tail),
        .cfg_full      (cfg_full),
        .cfg_overrun   (cfg_overrun),
        .commit_err    (commit_err)
    );

    for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
        logic [SEL_W-1:0] sel;
        logic             pin_val;

        assign sel = act[gi*SEL_W +: SEL_W];

        // Even inputs tap the left track, odd inputs the right track at the same index;
        // any select past the last input falls through to the 0 default.
        always_comb begin
            pin_val = 1'b0;
            for (int m = 0; m < MUX_SIZE / 2; m++) begin
                if (sel == SEL_W'(2 * m))
                    pin_val = chan.chanx_left_in[TW'(track_of(gi, m, TRACK_STRIDE, CHAN_W))];
                if (sel == SEL_W'(2 * m + 1))
                    pin_val = chan.chanx_right_in[TW'(track_of(gi, m, TRACK_STRIDE, CHAN_W))];
            end
        end

        assign ipin[gi] = pin_val;
    end

    assign chan.ipin_out        = ipin;
    assign chan.chanx_left_out  = chan.chanx_right_in;
    assign chan.chanx_right_out = chan.chanx_left_in;

endmodule

// File: tb/tb_cbx_param_dbuf.sv
// Directed bench for cbx_param_dbuf at default parameters (SEL_W=4, CFG_BITS=36).
module tb_cbx_param_dbuf;
    logic prog_clk;
    logic pReset;
    logic config_enable;
    logic ccff_head;
    logic cfg_commit;
    logic ccff_tail;
    logic cfg_full;
    logic cfg_overrun;
    logic commit_err;

    int vectors;
    int miscompares;

    logic [63:0] exp_q[$];
    string       tag_q[$];

    cbx_param_dbuf_if #(.CHAN_W(20), .NUM_IPIN(9)) chan ();

    cbx_param_dbuf #(
        .CHAN_W       (20),
        .NUM_IPIN     (9),
        .MUX_SIZE     (10),
        .TRACK_STRIDE (2)
    ) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .config_enable (config_enable),
        .ccff_head     (ccff_head),
        .cfg_commit    (cfg_commit),
        .ccff_tail     (ccff_tail),
        .cfg_full      (cfg_full),
        .cfg_overrun   (cfg_overrun),
        .commit_err    (commit_err),
        .chan          (chan)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic shift_bit(input logic b, input logic c);
        config_enable = 1'b1;
        ccff_head     = b;
        cfg_commit    = c;
        tick();
        config_enable = 1'b0;
        cfg_commit    = 1'b0;
    endtask

    // Sends v[hi] first down to v[lo], so a full 35..0 load lands v in the shadow as-is.
    task automatic shift_range(input logic [35:0] v, input int hi, input int lo);
        for (int k = hi; k >= lo; k--) shift_bit(v[k], 1'b0);
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    logic [35:0] v1, v2, v3, v4;

    initial begin
        vectors       = 0;
        miscompares   = 0;
        pReset        = 1'b0;
        config_enable = 1'b0;
        ccff_head     = 1'b0;
        cfg_commit    = 1'b0;
        chan.chanx_left_in  = 20'h00008;
        chan.chanx_right_in = 20'h00000;
        v1 = 36'h000000005;
        v2 = 36'h111111111;
        v3 = 36'h000000001;
        v4 = 36'h000000C00;

        repeat (2) tick();
        pReset = 1'b1;
        tick();

        // Reset asserted asynchronously while the chain is shifting ones.
        config_enable = 1'b1;
        ccff_head     = 1'b1;
        repeat (3) tick();
        #2 pReset = 1'b0;
        #1;
        push_exp("rst_async_full", 64'd0);    check(64'(cfg_full));
        config_enable = 1'b0;
        ccff_head     = 1'b0;
        tick();
        pReset = 1'b1;
        tick();
        push_exp("rst_full", 64'd0);          check(64'(cfg_full));
        push_exp("rst_overrun", 64'd0);       check(64'(cfg_overrun));
        push_exp("rst_commit_err", 64'd0);    check(64'(commit_err));
        push_exp("rst_tail", 64'd0);          check(64'(ccff_tail));
        push_exp("rst_ipin3", 64'd1);         check(64'(chan.ipin_out[3]));
        push_exp("rst_ipin_all", 64'h008);    check(64'(chan.ipin_out));

        chan.chanx_left_in  = 20'hABCDE;
        chan.chanx_right_in = 20'h13579;
        #1;
        push_exp("pass_left_out", 64'h13579);  check(64'(chan.chanx_left_out));
        push_exp("pass_right_out", 64'hABCDE); check(64'(chan.chanx_right_out));

        // Full load: pin 0 select 5 taps chanx_right_in[4].
        chan.chanx_left_in  = 20'h00000;
        chan.chanx_right_in = 20'h00010;
        shift_range(v1, 35, 1);
        push_exp("load35_not_full", 64'd0);   check(64'(cfg_full));
        shift_range(v1, 0, 0);
        push_exp("load36_full", 64'd1);       check(64'(cfg_full));
        push_exp("precommit_ipin", 64'h000);  check(64'(chan.ipin_out));
        do_commit();
        push_exp("commit1_full_clr", 64'd0);  check(64'(cfg_full));
        push_exp("commit1_no_err", 64'd0);    check(64'(commit_err));
        push_exp("commit1_ipin", 64'h001);    check(64'(chan.ipin_out));

        // Short load is rejected; one more bit completes it.
        chan.chanx_right_in = 20'h00155;
        shift_range(v2, 35, 1);
        push_exp("short_not_full", 64'd0);    check(64'(cfg_full));
        do_commit();
        push_exp("short_commit_err", 64'd1);  check(64'(commit_err));
        push_exp("short_act_kept", 64'h001);  check(64'(chan.ipin_out));
        tick();
        push_exp("short_err_pulse", 64'd0);   check(64'(commit_err));
        shift_range(v2, 0, 0);
        push_exp("short_then_full", 64'd1);   check(64'(cfg_full));
        do_commit();
        push_exp("commit2_no_err", 64'd0);    check(64'(commit_err));
        push_exp("commit2_ipin", 64'h155);    check(64'(chan.ipin_out));

        // Overrun: leading 1 reaches the tail after exactly 36 shifts.
        shift_bit(1'b1, 1'b0);
        for (int k = 0; k < 35; k++) shift_bit(1'b0, 1'b0);
        push_exp("ovr36_full", 64'd1);        check(64'(cfg_full));
        push_exp("ovr36_no_ovr", 64'd0);      check(64'(cfg_overrun));
        push_exp("ovr36_tail", 64'd1);        check(64'(ccff_tail));
        shift_bit(1'b1, 1'b0);
        push_exp("ovr37_ovr", 64'd1);         check(64'(cfg_overrun));
        push_exp("ovr37_tail", 64'd0);        check(64'(ccff_tail));
        do_commit();
        push_exp("ovr_commit_err", 64'd1);    check(64'(commit_err));
        push_exp("ovr_sticky", 64'd1);        check(64'(cfg_overrun));
        push_exp("ovr_act_kept", 64'h155);    check(64'(chan.ipin_out));

        pReset = 1'b0;
        tick();
        pReset = 1'b1;
        chan.chanx_left_in = 20'h000A5;
        tick();
        push_exp("rst2_overrun", 64'd0);      check(64'(cfg_overrun));
        push_exp("rst2_ipin", 64'h0A5);       check(64'(chan.ipin_out));

        // Shift and accepted commit on the same edge.
        chan.chanx_left_in  = 20'h00000;
        chan.chanx_right_in = 20'h00001;
        shift_range(v3, 35, 0);
        push_exp("sim_pre_full", 64'd1);      check(64'(cfg_full));
        shift_bit(v4[35], 1'b1);
        push_exp("sim_full_clr", 64'd0);      check(64'(cfg_full));
        push_exp("sim_no_ovr", 64'd0);        check(64'(cfg_overrun));
        push_exp("sim_no_err", 64'd0);        check(64'(commit_err));
        push_exp("sim_ipin", 64'h001);        check(64'(chan.ipin_out));
        shift_range(v4, 34, 1);
        push_exp("sim_cnt35_not_full", 64'd0); check(64'(cfg_full));
        shift_range(v4, 0, 0);
        push_exp("sim_cnt36_full", 64'd1);    check(64'(cfg_full));

        // Pin 2 select 12 is out of range and must read 0.
        do_commit();
        push_exp("oor_no_err", 64'd0);        check(64'(commit_err));
        chan.chanx_left_in  = 20'hFFFFF;
        chan.chanx_right_in = 20'hFFFFF;
        #1;
        push_exp("oor_ipin2", 64'd0);         check(64'(chan.ipin_out[2]));
        push_exp("oor_ipin_all", 64'h1FB);    check(64'(chan.ipin_out));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
